// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA raster timing generator.
// Holds FSM states, standard mode timing sets and sync polarity values.
package vga_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } vga_state_e;

  localparam logic SYNC_ACT_LOW  = 1'b0;
  localparam logic SYNC_ACT_HIGH = 1'b1;

  // 640x480 @ 60 Hz, 25.175 MHz pixel clock
  localparam int VGA640_H_DISP = 640;
  localparam int VGA640_H_FP   = 16;
  localparam int VGA640_H_SYNC = 96;
  localparam int VGA640_H_BP   = 48;
  localparam int VGA640_V_DISP = 480;
  localparam int VGA640_V_FP   = 10;
  localparam int VGA640_V_SYNC = 2;
  localparam int VGA640_V_BP   = 33;

  // 800x600 @ 60 Hz, 40 MHz pixel clock, positive syncs
  localparam int SVGA800_H_DISP = 800;
  localparam int SVGA800_H_FP   = 40;
  localparam int SVGA800_H_SYNC = 128;
  localparam int SVGA800_H_BP   = 88;
  localparam int SVGA800_V_DISP = 600;
  localparam int SVGA800_V_FP   = 1;
  localparam int SVGA800_V_SYNC = 4;
  localparam int SVGA800_V_BP   = 23;

endpackage

// File: rtl/vga_tick_div.sv
// Pixel-enable generator: free-running counter, tick high on the last clk of each pixel.
// Latency: combinational from the counter register; no backpressure, always running.
module vga_tick_div #(
  parameter int CLK_DIV = 2,
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1
) (
  input  logic clk,
  input  logic reset,
  output logic tick_o
);

  localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_q;
  logic [DW-1:0] div_d;

  // With CLK_DIV==1 LAST is 0 and the counter never leaves 0, so tick stays high.
  assign tick_o = (div_q == LAST);
  assign div_d  = tick_o ? '0 : div_q + DW'(1);

  always_ff @(posedge clk) begin
    if (reset) div_q <= '0;
    else       div_q <= div_d;
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA/DVI raster timing generator with frame-complete run/stop control.
// All outputs registered on the counter edge; optional frame_cnt via VGA_TIMING_FRAME_CNT_EN.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int   H_DISP  = VGA640_H_DISP,
  parameter int   H_FP    = VGA640_H_FP,
  parameter int   H_SYNC  = VGA640_H_SYNC,
  parameter int   H_BP    = VGA640_H_BP,
  parameter int   V_DISP  = VGA640_V_DISP,
  parameter int   V_FP    = VGA640_V_FP,
  parameter int   V_SYNC  = VGA640_V_SYNC,
  parameter int   V_BP    = VGA640_V_BP,
  parameter logic HS_POL  = SYNC_ACT_LOW,
  parameter logic VS_POL  = SYNC_ACT_LOW,
  parameter int   CLK_DIV = 2,
  localparam int  H_TOT   = H_DISP + H_FP + H_SYNC + H_BP,
  localparam int  V_TOT   = V_DISP + V_FP + V_SYNC + V_BP,
  localparam int  H_W     = $clog2(H_TOT),
  localparam int  V_W     = $clog2(V_TOT)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           run,
  output logic           p_tick,
  output logic           hsync,
  output logic           vsync,
  output logic           de,
  output logic [H_W-1:0] pixel_x,
  output logic [V_W-1:0] pixel_y,
  output logic           sol,
  output logic           sof,
`ifdef VGA_TIMING_FRAME_CNT_EN
  output logic [15:0]    frame_cnt,
`endif
  output logic           busy
);

  localparam logic [H_W-1:0] X_LAST   = H_W'(H_TOT - 1);
  localparam logic [V_W-1:0] Y_LAST   = V_W'(V_TOT - 1);
  localparam int             HS_START = H_DISP + H_FP;
  localparam int             HS_END   = H_DISP + H_FP + H_SYNC;
  localparam int             VS_START = V_DISP + V_FP;
  localparam int             VS_END   = V_DISP + V_FP + V_SYNC;

  logic tick;

  vga_tick_div #(.CLK_DIV(CLK_DIV)) u_tick_div (
    .clk    (clk),
    .reset  (reset),
    .tick_o (tick)
  );

  vga_state_e     state_q, state_d;
  logic [H_W-1:0] x_q, x_d, nx, ld_x;
  logic [V_W-1:0] y_q, y_d, ny, ld_y;
  logic           p_tick_q, p_tick_d;
  logic           hs_q, hs_d, vs_q, vs_d, de_q, de_d;
  logic           sol_q, sol_d, sof_q, sof_d, busy_q, busy_d;
  logic           ld, go_idle, last_px;

  assign last_px = (x_q == X_LAST) && (y_q == Y_LAST);
  assign nx      = (x_q == X_LAST) ? '0 : x_q + H_W'(1);
  assign ny      = (x_q != X_LAST) ? y_q : ((y_q == Y_LAST) ? '0 : y_q + V_W'(1));

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    hs_d     = hs_q;
    vs_d     = vs_q;
    de_d     = de_q;
    p_tick_d = tick;
    sol_d    = 1'b0;
    sof_d    = 1'b0;
    ld       = 1'b0;
    go_idle  = 1'b0;
    ld_x     = nx;
    ld_y     = ny;

    case (state_q)
      ST_IDLE: begin
        if (tick && run) begin
          state_d = ST_RUN;
          ld      = 1'b1;
          ld_x    = '0;
          ld_y    = '0;
        end
      end
      ST_RUN, ST_DRAIN: begin
        state_d = run ? ST_RUN : ST_DRAIN;
        // A stop only takes effect on the final pixel, so frames are always whole.
        if (tick && last_px && !run) begin
          state_d = ST_IDLE;
          go_idle = 1'b1;
        end else if (tick) begin
          ld = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        go_idle = 1'b1;
      end
    endcase

    if (ld) begin
      x_d   = ld_x;
      y_d   = ld_y;
      de_d  = (int'(ld_x) < H_DISP) && (int'(ld_y) < V_DISP);
      hs_d  = ((int'(ld_x) >= HS_START) && (int'(ld_x) < HS_END)) ? HS_POL : ~HS_POL;
      vs_d  = ((int'(ld_y) >= VS_START) && (int'(ld_y) < VS_END)) ? VS_POL : ~VS_POL;
      sol_d = (ld_x == '0);
      sof_d = (ld_x == '0) && (ld_y == '0);
    end
    if (go_idle) begin
      x_d  = '0;
      y_d  = '0;
      de_d = 1'b0;
      hs_d = ~HS_POL;
      vs_d = ~VS_POL;
    end
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      x_q      <= '0;
      y_q      <= '0;
      p_tick_q <= 1'b0;
      hs_q     <= ~HS_POL;
      vs_q     <= ~VS_POL;
      de_q     <= 1'b0;
      sol_q    <= 1'b0;
      sof_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      p_tick_q <= p_tick_d;
      hs_q     <= hs_d;
      vs_q     <= vs_d;
      de_q     <= de_d;
      sol_q    <= sol_d;
      sof_q    <= sof_d;
      busy_q   <= busy_d;
    end
  end

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] frame_cnt_q;
  logic [15:0] frame_cnt_d;

  assign frame_cnt_d = sof_d ? frame_cnt_q + 16'd1 : frame_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) frame_cnt_q <= '0;
    else       frame_cnt_q <= frame_cnt_d;
  end

  assign frame_cnt = frame_cnt_q;
`endif

  assign p_tick  = p_tick_q;
  assign hsync   = hs_q;
  assign vsync   = vs_q;
  assign de      = de_q;
  assign pixel_x = x_q;
  assign pixel_y = y_q;
  assign sol     = sol_q;
  assign sof     = sof_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: two small-mode generators driven with random run/reset, checked each clk
// against a linear-pixel-index reference model through expectation queues.
module tb_vga_timing_gen;

  localparam int A_HD = 8, A_HF = 2, A_HS = 3, A_HB = 2;
  localparam int A_VD = 4, A_VF = 1, A_VS = 2, A_VB = 1;
  localparam int A_DIV = 3;
  localparam int A_HT = A_HD + A_HF + A_HS + A_HB;
  localparam int A_VT = A_VD + A_VF + A_VS + A_VB;
  localparam int A_HW = $clog2(A_HT);
  localparam int A_VW = $clog2(A_VT);

  localparam int B_HD = 6, B_HF = 1, B_HS = 2, B_HB = 2;
  localparam int B_VD = 3, B_VF = 1, B_VS = 1, B_VB = 2;
  localparam int B_DIV = 1;
  localparam int B_HT = B_HD + B_HF + B_HS + B_HB;
  localparam int B_VT = B_VD + B_VF + B_VS + B_VB;
  localparam int B_HW = $clog2(B_HT);
  localparam int B_VW = $clog2(B_VT);

  localparam int NCYC = 30000;

  typedef struct {
    int htot, hdisp, hs0, hs1, vtot, vdisp, vs0, vs1, div;
    logic hpol, vpol;
  } cfg_t;

  typedef struct {
    logic p_tick, hs, vs, de, sol, sof, busy;
    int x, y;
    logic [15:0] fcnt;
  } exp_t;

  typedef struct {
    int n;
    bit active;
    int p;
    exp_t last;
  } mst_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0, run0, rst1, run1;
  logic pt0, hs0, vs0, de0, sol0, sof0, busy0;
  logic pt1, hs1, vs1, de1, sol1, sof1, busy1;
  logic [A_HW-1:0] px0;
  logic [A_VW-1:0] py0;
  logic [B_HW-1:0] px1;
  logic [B_VW-1:0] py1;
  logic [15:0] fc0, fc1;

  vga_timing_gen #(
    .H_DISP(A_HD), .H_FP(A_HF), .H_SYNC(A_HS), .H_BP(A_HB),
    .V_DISP(A_VD), .V_FP(A_VF), .V_SYNC(A_VS), .V_BP(A_VB),
    .HS_POL(1'b0), .VS_POL(1'b0), .CLK_DIV(A_DIV)
  ) dut0 (
    .clk(clk), .reset(rst0), .run(run0), .p_tick(pt0), .hsync(hs0), .vsync(vs0),
    .de(de0), .pixel_x(px0), .pixel_y(py0), .sol(sol0), .sof(sof0),
`ifdef VGA_TIMING_FRAME_CNT_EN
    .frame_cnt(fc0),
`endif
    .busy(busy0)
  );

  vga_timing_gen #(
    .H_DISP(B_HD), .H_FP(B_HF), .H_SYNC(B_HS), .H_BP(B_HB),
    .V_DISP(B_VD), .V_FP(B_VF), .V_SYNC(B_VS), .V_BP(B_VB),
    .HS_POL(1'b1), .VS_POL(1'b1), .CLK_DIV(B_DIV)
  ) dut1 (
    .clk(clk), .reset(rst1), .run(run1), .p_tick(pt1), .hsync(hs1), .vsync(vs1),
    .de(de1), .pixel_x(px1), .pixel_y(py1), .sol(sol1), .sof(sof1),
`ifdef VGA_TIMING_FRAME_CNT_EN
    .frame_cnt(fc1),
`endif
    .busy(busy1)
  );

`ifndef VGA_TIMING_FRAME_CNT_EN
  assign fc0 = 16'h0;
  assign fc1 = 16'h0;
`endif

  int checks = 0;
  int errors = 0;
  exp_t q0[$];
  exp_t q1[$];

  function automatic exp_t idle_val(input cfg_t c);
    exp_t e;
    e.p_tick = 1'b0; e.hs = ~c.hpol; e.vs = ~c.vpol; e.de = 1'b0;
    e.sol = 1'b0; e.sof = 1'b0; e.busy = 1'b0; e.x = 0; e.y = 0; e.fcnt = 16'h0;
    return e;
  endfunction

  // Raster position kept as one linear pixel index over the whole frame.
  task automatic model_step(input cfg_t c, input logic run_v, input logic rst_v,
                            input mst_t si, output mst_t so, output exp_t e);
    bit tick, upd, stop;
    int x, y;
    logic [15:0] fc;
    so = si; e = si.last; e.sol = 1'b0; e.sof = 1'b0; upd = 0; stop = 0;
    if (rst_v) begin
      so.n = 0; so.active = 0; so.p = 0;
      e = idle_val(c);
    end else begin
      tick = (si.n == c.div - 1);
      so.n = tick ? 0 : si.n + 1;
      e.p_tick = tick;
      if (tick) begin
        if (!si.active) begin
          if (run_v) begin so.active = 1; so.p = 0; upd = 1; end
        end else if (si.p == c.htot * c.vtot - 1) begin
          if (run_v) begin so.p = 0; upd = 1; end
          else stop = 1;
        end else begin
          so.p = si.p + 1; upd = 1;
        end
      end
      if (stop) begin
        fc = e.fcnt; so.active = 0;
        e = idle_val(c); e.p_tick = 1'b1; e.fcnt = fc;
      end
      if (upd) begin
        x = so.p % c.htot; y = so.p / c.htot;
        e.x = x; e.y = y;
        e.de = (x < c.hdisp) && (y < c.vdisp);
        e.hs = (x >= c.hs0 && x < c.hs1) ? c.hpol : ~c.hpol;
        e.vs = (y >= c.vs0 && y < c.vs1) ? c.vpol : ~c.vpol;
        e.sol = (x == 0); e.sof = (so.p == 0); e.busy = 1'b1;
        if (e.sof) e.fcnt = e.fcnt + 16'd1;
      end
    end
    so.last = e;
  endtask

  task automatic cmp(input string nm, input exp_t e, input exp_t g);
    bit bad;
    checks++;
    bad = (g.p_tick !== e.p_tick) || (g.hs !== e.hs) || (g.vs !== e.vs) || (g.de !== e.de) ||
          (g.sol !== e.sol) || (g.sof !== e.sof) || (g.busy !== e.busy) ||
          (g.x != e.x) || (g.y != e.y);
`ifdef VGA_TIMING_FRAME_CNT_EN
    bad = bad || (g.fcnt !== e.fcnt);
`endif
    if (bad) begin
      errors++;
      $display("FAIL %s t=%0t got pt%0b hs%0b vs%0b de%0b sol%0b sof%0b busy%0b x%0d y%0d fc%0h | exp pt%0b hs%0b vs%0b de%0b sol%0b sof%0b busy%0b x%0d y%0d fc%0h",
               nm, $time, g.p_tick, g.hs, g.vs, g.de, g.sol, g.sof, g.busy, g.x, g.y, g.fcnt,
               e.p_tick, e.hs, e.vs, e.de, e.sol, e.sof, e.busy, e.x, e.y, e.fcnt);
    end
  endtask

  initial begin
    exp_t e, g;
    forever begin
      @(negedge clk);
      if (q0.size() > 0) begin
        e = q0.pop_front();
        g.p_tick = pt0; g.hs = hs0; g.vs = vs0; g.de = de0; g.sol = sol0; g.sof = sof0;
        g.busy = busy0; g.x = int'(px0); g.y = int'(py0); g.fcnt = fc0;
        cmp("dut0", e, g);
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        g.p_tick = pt1; g.hs = hs1; g.vs = vs1; g.de = de1; g.sol = sol1; g.sof = sof1;
        g.busy = busy1; g.x = int'(px1); g.y = int'(py1); g.fcnt = fc1;
        cmp("dut1", e, g);
      end
    end
  end

  initial begin
    cfg_t ca, cb;
    mst_t st0, st1, nst;
    exp_t e;
    int len0, len1;

    ca.htot = A_HT; ca.hdisp = A_HD; ca.hs0 = A_HD + A_HF; ca.hs1 = A_HD + A_HF + A_HS;
    ca.vtot = A_VT; ca.vdisp = A_VD; ca.vs0 = A_VD + A_VF; ca.vs1 = A_VD + A_VF + A_VS;
    ca.div = A_DIV; ca.hpol = 1'b0; ca.vpol = 1'b0;
    cb.htot = B_HT; cb.hdisp = B_HD; cb.hs0 = B_HD + B_HF; cb.hs1 = B_HD + B_HF + B_HS;
    cb.vtot = B_VT; cb.vdisp = B_VD; cb.vs0 = B_VD + B_VF; cb.vs1 = B_VD + B_VF + B_VS;
    cb.div = B_DIV; cb.hpol = 1'b1; cb.vpol = 1'b1;

    st0.n = 0; st0.active = 0; st0.p = 0; st0.last = idle_val(ca);
    st1.n = 0; st1.active = 0; st1.p = 0; st1.last = idle_val(cb);
    rst0 = 1'b1; rst1 = 1'b1; run0 = 1'b0; run1 = 1'b0;
    len0 = 6; len1 = 9;

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge clk);
      #1;
      rst0 = (cyc < 3) || ($urandom_range(0, 2499) == 0);
      rst1 = (cyc < 3) || ($urandom_range(0, 2499) == 0);
      if (len0 == 0) begin
        run0 = ~run0;
        len0 = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 40) : $urandom_range(100, 900);
      end else len0--;
      if (len1 == 0) begin
        run1 = ~run1;
        len1 = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 30) : $urandom_range(80, 600);
      end else len1--;
`ifdef VGA_TIMING_FRAME_CNT_EN
      if (cyc == NCYC / 2) begin
        force dut0.frame_cnt_q = 16'hFFFF;
        release dut0.frame_cnt_q;
        st0.last.fcnt = 16'hFFFF;
      end
`endif
      model_step(ca, run0, rst0, st0, nst, e);
      st0 = nst;
      q0.push_back(e);
      model_step(cb, run1, rst1, st1, nst, e);
      st1 = nst;
      q1.push_back(e);
    end

    @(negedge clk);
    #2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
